// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared constants for the decode-stage hazard scoreboard: instruction kind
// encoding as seen by decode, and default register-file geometry.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    // Default architectural register count (x0 is hard-wired zero)
    localparam int REG_NUM_DEF   = 32;
    // Default register index width
    localparam int REG_IDX_W_DEF = 5;

    // Instruction class as classified by decode; the reserved code behaves as ALU
    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,
        KIND_LOAD = 2'b01,
        KIND_LONG = 2'b10,
        KIND_RSVD = 2'b11
    } kind_e;

endpackage

// File: rtl/hazard_scoreboard_pending.sv
// -----------------------------------------------------------------------------
// sb_pending_bank
// Per-register "long result still in flight" bank plus the long-unit busy flag
// and a sticky error flag.
//   clk, rst   : clock, synchronous active-high reset
//   set_en     : a long op issues this cycle (marks the unit busy)
//   set_wen    : that long op writes a destination register
//   set_idx    : destination of the issuing long op
//   clr_en     : the long unit writes back this cycle
//   clr_idx    : destination of the completing long op
//   pending    : pending mask, bit 0 never set
//   busy       : long unit occupied
//   err        : sticky, a completion arrived for a register not pending
// A completion is applied before a same-cycle set, so an old bit can be cleared
// and a new one set on the same edge.
// -----------------------------------------------------------------------------
module sb_pending_bank
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_NUM   = REG_NUM_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic                 set_wen,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    output logic [REG_NUM-1:0]   pending,
    output logic                 busy,
    output logic                 err
);

    logic [REG_NUM-1:0] pending_r;
    logic [REG_NUM-1:0] pending_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               err_r;
    logic               err_nxt_s;

    // Next-state: completion (clear) first, then issue (set)
    always_comb begin
        pending_nxt_s = pending_r;
        busy_nxt_s    = busy_r;
        err_nxt_s     = err_r;
        if (clr_en) begin
            busy_nxt_s = 1'b0;
            if (pending_r[clr_idx]) begin
                pending_nxt_s[clr_idx] = 1'b0;
            end else begin
                // Unexpected completion: leave the bank alone, flag it
                err_nxt_s = 1'b1;
            end
        end else begin
            busy_nxt_s = busy_r;
        end
        if (set_en) begin
            busy_nxt_s = 1'b1;
            if (set_wen && (set_idx != {REG_IDX_W{1'b0}})) begin
                pending_nxt_s[set_idx] = 1'b1;
            end else begin
                pending_nxt_s = pending_nxt_s;
            end
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        // x0 can never be in flight
        pending_nxt_s[0] = 1'b0;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= {REG_NUM{1'b0}};
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            busy_r    <= busy_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign pending = pending_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Decode-side hazard tracker covering what EX/MEM forwarding cannot: a load
// one stage ahead (load-use) and results of the single multi-cycle unit.
//   clk, rst                      : clock, synchronous active-high reset
//   id_valid_i                    : decode holds a valid instruction
//   id_rs1_idx_i / id_rs1_used_i  : source 1 index / read enable
//   id_rs2_idx_i / id_rs2_used_i  : source 2 index / read enable
//   id_rd_idx_i / id_rd_wen_i     : destination index / write enable
//   id_kind_i                     : 00 ALU, 01 LOAD, 10 LONG, 11 as ALU
//   flush_i                       : squash the instruction entering EX
//   long_done_i / long_rd_idx_i   : long unit write-back and its destination
//   stall_o                       : hold PC/IF/ID, bubble into EX (combinational)
//   long_busy_o                   : long unit occupied
//   pending_o                     : per-register long-op pending mask
//   err_o                         : sticky unexpected-completion flag
// There is no same-cycle bypass of long_done_i: the consumer still stalls in
// the write-back cycle and picks the value from the register file afterwards.
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_NUM   = REG_NUM_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_i,
    input  logic [REG_IDX_W-1:0] id_rs1_idx_i,
    input  logic                 id_rs1_used_i,
    input  logic [REG_IDX_W-1:0] id_rs2_idx_i,
    input  logic                 id_rs2_used_i,
    input  logic [REG_IDX_W-1:0] id_rd_idx_i,
    input  logic                 id_rd_wen_i,
    input  logic [1:0]           id_kind_i,
    input  logic                 flush_i,
    input  logic                 long_done_i,
    input  logic [REG_IDX_W-1:0] long_rd_idx_i,
    output logic                 stall_o,
    output logic                 long_busy_o,
    output logic [REG_NUM-1:0]   pending_o,
    output logic                 err_o
);

    localparam logic [REG_IDX_W-1:0] IDX_ZERO = {REG_IDX_W{1'b0}};

    logic                 ex_load_v_r;
    logic [REG_IDX_W-1:0] ex_load_rd_r;
    logic [REG_NUM-1:0]   pending_s;
    logic                 long_busy_s;
    logic                 err_s;
    logic                 is_load_s;
    logic                 is_long_s;
    logic                 rs1_live_s;
    logic                 rs2_live_s;
    logic                 rd_live_s;
    logic                 load_use_s;
    logic                 raw_s;
    logic                 waw_s;
    logic                 struct_s;
    logic                 stall_s;
    logic                 issue_s;

    // Decode the instruction kind; the reserved code falls through as ALU
    always_comb begin
        is_load_s = 1'b0;
        is_long_s = 1'b0;
        case (kind_e'(id_kind_i))
            KIND_LOAD: is_load_s = 1'b1;
            KIND_LONG: is_long_s = 1'b1;
            default: begin
                is_load_s = 1'b0;
                is_long_s = 1'b0;
            end
        endcase
    end

    // Hazard terms and the gated stall; x0 operands never participate
    always_comb begin
        rs1_live_s = id_rs1_used_i && (id_rs1_idx_i != IDX_ZERO);
        rs2_live_s = id_rs2_used_i && (id_rs2_idx_i != IDX_ZERO);
        rd_live_s  = id_rd_wen_i && (id_rd_idx_i != IDX_ZERO);
        if (ex_load_v_r) begin
            load_use_s = (rs1_live_s && (id_rs1_idx_i == ex_load_rd_r)) ||
                         (rs2_live_s && (id_rs2_idx_i == ex_load_rd_r));
        end else begin
            load_use_s = 1'b0;
        end
        raw_s    = (rs1_live_s && pending_s[id_rs1_idx_i]) ||
                   (rs2_live_s && pending_s[id_rs2_idx_i]);
        waw_s    = rd_live_s && pending_s[id_rd_idx_i];
        struct_s = is_long_s && long_busy_s;
        if (id_valid_i) begin
            stall_s = load_use_s || raw_s || waw_s || struct_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign issue_s = id_valid_i && !stall_s;

    // Load tracker: remembers a load that has just entered EX
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_load_v_r  <= 1'b0;
            ex_load_rd_r <= IDX_ZERO;
        end else if (flush_i) begin
            ex_load_v_r  <= 1'b0;
            ex_load_rd_r <= ex_load_rd_r;
        end else if (issue_s && is_load_s && rd_live_s) begin
            ex_load_v_r  <= 1'b1;
            ex_load_rd_r <= id_rd_idx_i;
        end else begin
            ex_load_v_r  <= 1'b0;
            ex_load_rd_r <= ex_load_rd_r;
        end
    end

    // Flush does not touch the bank: long ops in flight predate the flush
    sb_pending_bank #(
        .REG_NUM   (REG_NUM),
        .REG_IDX_W (REG_IDX_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_s && is_long_s),
        .set_wen (id_rd_wen_i),
        .set_idx (id_rd_idx_i),
        .clr_en  (long_done_i),
        .clr_idx (long_rd_idx_i),
        .pending (pending_s),
        .busy    (long_busy_s),
        .err     (err_s)
    );

    assign stall_o     = stall_s;
    assign long_busy_o = long_busy_s;
    assign pending_o   = pending_s;
    assign err_o       = err_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid_i = 1'b0;
    logic [IW-1:0] id_rs1_idx_i = '0;
    logic          id_rs1_used_i = 1'b0;
    logic [IW-1:0] id_rs2_idx_i = '0;
    logic          id_rs2_used_i = 1'b0;
    logic [IW-1:0] id_rd_idx_i = '0;
    logic          id_rd_wen_i = 1'b0;
    logic [1:0]    id_kind_i = 2'b00;
    logic          flush_i = 1'b0;
    logic          long_done_i = 1'b0;
    logic [IW-1:0] long_rd_idx_i = '0;
    logic          stall_o;
    logic          long_busy_o;
    logic [NR-1:0] pending_o;
    logic          err_o;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_NUM(NR), .REG_IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i),
        .id_rs1_idx_i(id_rs1_idx_i), .id_rs1_used_i(id_rs1_used_i),
        .id_rs2_idx_i(id_rs2_idx_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_idx_i(id_rd_idx_i), .id_rd_wen_i(id_rd_wen_i),
        .id_kind_i(id_kind_i), .flush_i(flush_i),
        .long_done_i(long_done_i), .long_rd_idx_i(long_rd_idx_i),
        .stall_o(stall_o), .long_busy_o(long_busy_o),
        .pending_o(pending_o), .err_o(err_o)
    );

    typedef struct packed {
        logic          stall;
        logic          busy;
        logic [NR-1:0] pend;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: architectural view of what is in flight
    int m_load_rd = -1;        // register a load in EX will produce, -1 if none
    bit m_pend[NR];            // registers owed by the long unit
    bit m_busy = 1'b0;
    bit m_err  = 1'b0;
    bit iss;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    // Monitor: compares the DUT against the queued expectation every cycle
    exp_t e_mon;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("stall",   32'(stall_o),     32'(e_mon.stall));
            chk("busy",    32'(long_busy_o), 32'(e_mon.busy));
            chk("pending", pending_o,        e_mon.pend);
            chk("err",     32'(err_o),       32'(e_mon.err));
        end
    end

    task automatic model_reset();
        m_load_rd = -1;
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        m_busy = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst           = 1'b1;
        id_valid_i    = 1'($urandom);
        id_rs1_idx_i  = IW'($urandom);
        id_rs1_used_i = 1'($urandom);
        id_rs2_idx_i  = IW'($urandom);
        id_rs2_used_i = 1'($urandom);
        id_rd_idx_i   = IW'($urandom);
        id_rd_wen_i   = 1'($urandom);
        id_kind_i     = 2'($urandom);
        flush_i       = 1'b0;
        long_done_i   = 1'b0;
        long_rd_idx_i = '0;
        model_reset();
    endtask

    // One decode cycle: drive, predict, queue the prediction, advance the model
    task automatic step(input bit v, input bit [1:0] k, input int rd, input bit wen,
                        input int rs1, input bit u1, input int rs2, input bit u2,
                        input bit fl, input bit dn, input int drd, output bit issued);
        exp_t          e;
        bit            st;
        bit [NR-1:0]   pv;
        @(posedge clk); #1;
        rst           = 1'b0;
        id_valid_i    = v;
        id_kind_i     = k;
        id_rd_idx_i   = rd[IW-1:0];
        id_rd_wen_i   = wen;
        id_rs1_idx_i  = rs1[IW-1:0];
        id_rs1_used_i = u1;
        id_rs2_idx_i  = rs2[IW-1:0];
        id_rs2_used_i = u2;
        flush_i       = fl;
        long_done_i   = dn;
        long_rd_idx_i = drd[IW-1:0];
        st = 1'b0;
        if (v) begin
            if (m_load_rd > 0 && ((u1 && rs1 == m_load_rd) || (u2 && rs2 == m_load_rd))) st = 1'b1;
            if (u1 && rs1 != 0 && m_pend[rs1]) st = 1'b1;
            if (u2 && rs2 != 0 && m_pend[rs2]) st = 1'b1;
            if (wen && rd != 0 && m_pend[rd]) st = 1'b1;
            if (k == 2'b10 && m_busy) st = 1'b1;
        end
        for (int i = 0; i < NR; i++) pv[i] = m_pend[i];
        e.stall = st;
        e.busy  = m_busy;
        e.pend  = pv;
        e.err   = m_err;
        exp_q.push_back(e);
        issued = v && !st;
        if (!fl && issued && k == 2'b01 && wen && rd != 0) m_load_rd = rd;
        else m_load_rd = -1;
        if (dn) begin
            if (m_pend[drd]) m_pend[drd] = 1'b0;
            else m_err = 1'b1;
            m_busy = 1'b0;
        end
        if (issued && k == 2'b10) begin
            m_busy = 1'b1;
            if (wen && rd != 0) m_pend[rd] = 1'b1;
        end
    endtask

    task automatic op(input bit [1:0] k, input int rd, input bit wen, input int rs1, input bit u1,
                      input int rs2, input bit u2, input bit fl = 1'b0, input bit dn = 1'b0,
                      input int drd = 0);
        step(1'b1, k, rd, wen, rs1, u1, rs2, u2, fl, dn, drd, iss);
    endtask

    task automatic idle(input bit dn = 1'b0, input int drd = 0);
        step(1'b0, 2'b00, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, dn, drd, iss);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [1:0] k;
        int  rd, rs1, rs2, env_rd, env_cnt;
        bit  wen, u1, u2, v, fl, dn, have;

        // Reset state
        do_reset();
        idle(); idle();

        // Load-use: one stall, then issue
        op(2'b01, 5, 1, 1, 1, 2, 1);
        op(2'b00, 6, 1, 5, 1, 0, 0);
        op(2'b00, 6, 1, 5, 1, 0, 0);
        idle();

        // x0 immunity
        op(2'b01, 0, 1, 1, 0, 0, 0);
        op(2'b00, 6, 1, 0, 1, 0, 1);
        op(2'b10, 0, 1, 1, 1, 2, 1);
        idle(); idle();
        do_reset();

        // Long RAW: consumer waits through the done cycle
        op(2'b10, 7, 1, 1, 1, 2, 1);
        op(2'b00, 8, 1, 1, 1, 7, 1);
        op(2'b00, 8, 1, 1, 1, 7, 1);
        op(2'b00, 8, 1, 1, 1, 7, 1, 1'b0, 1'b1, 7);
        op(2'b00, 8, 1, 1, 1, 7, 1);
        idle();

        // Structural and WAW
        op(2'b10, 3, 1, 1, 1, 2, 1);
        op(2'b00, 3, 1, 0, 0, 0, 0);
        op(2'b10, 4, 1, 1, 1, 2, 1);
        op(2'b10, 4, 1, 1, 1, 2, 1, 1'b0, 1'b1, 3);
        op(2'b10, 4, 1, 1, 1, 2, 1);
        op(2'b00, 4, 1, 0, 0, 0, 0);
        op(2'b00, 4, 1, 0, 0, 0, 0, 1'b0, 1'b1, 4);
        op(2'b00, 4, 1, 0, 0, 0, 0);
        idle();

        // Flush squashes the load tracker
        op(2'b01, 9, 1, 1, 1, 0, 0, 1'b1);
        op(2'b00, 10, 1, 9, 1, 9, 1);
        op(2'b01, 9, 1, 1, 1, 0, 0);
        op(2'b00, 10, 1, 9, 1, 0, 0, 1'b1);
        op(2'b00, 10, 1, 9, 1, 0, 0);
        idle();

        // Unexpected completion is sticky until reset
        idle(1'b1, 12);
        idle(); idle(); idle();
        do_reset();
        idle(); idle();

        // Randomized traffic with a long unit of random latency
        have = 1'b0; env_rd = 0; env_cnt = 0;
        k = 2'b00; rd = 0; wen = 1'b0; rs1 = 0; u1 = 1'b0; rs2 = 0; u2 = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!have) begin
                k   = 2'($urandom_range(0, 3));
                rs1 = $urandom_range(0, 7);
                rs2 = $urandom_range(0, 7);
                u1  = 1'($urandom);
                u2  = 1'($urandom);
                if (k == 2'b10) begin
                    rd  = $urandom_range(1, 7);
                    wen = 1'b1;
                end else begin
                    rd  = $urandom_range(0, 7);
                    wen = 1'($urandom);
                end
            end
            v  = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 9) == 0);
            dn = m_busy && (env_cnt == 0);
            if (m_busy && env_cnt > 0) env_cnt--;
            step(v, k, rd, wen, rs1, u1, rs2, u2, fl, dn, env_rd, iss);
            if (iss && k == 2'b10) begin
                env_rd  = rd;
                env_cnt = $urandom_range(0, 4);
            end
            have = v && !iss && !fl;
        end

        idle();
        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
